// File: rtl/io_mux_pkg.sv
// Shared constants for the pad multiplexer: register offsets, function indices,
// the select-width helper and the config-port FSM state type.
package io_mux_pkg;

  localparam logic [3:0] IO_MUX_FSEL = 4'h0;
  localparam logic [3:0] IO_MUX_OD   = 4'h4;
  localparam logic [3:0] IO_MUX_LOCK = 4'h8;
  localparam logic [3:0] IO_MUX_IN   = 4'hC;

  localparam int FN_GPIO = 0;
  localparam int FN_SPI  = 1;
  localparam int FN_I2C  = 2;
  localparam int FN_PWM  = 3;

  typedef enum logic {
    CFG_IDLE = 1'b0,
    CFG_ACK  = 1'b1
  } cfg_state_e;

  // Width of one pin's function-select field; at least one bit.
  function automatic int fsel_w(input int num_funcs);
    return (num_funcs <= 2) ? 1 : $clog2(num_funcs);
  endfunction

endpackage

// File: rtl/io_pin_mux_if.sv
// Register-access port of the pad multiplexer (master drives requests, slave answers).
interface io_pin_mux_if;
  // Handshake: master raises cfg_valid with cfg_we/cfg_addr/cfg_wdata stable and holds
  // them until cfg_ready; slave samples cfg_valid on a clk edge and answers with a
  // one-cycle cfg_ready on the following cycle, cfg_rdata valid only during that cycle.
  // The ready cycle never accepts a new request.
  logic        cfg_valid;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        cfg_ready;

  modport master (
    output cfg_valid, cfg_we, cfg_addr, cfg_wdata,
    input  cfg_rdata, cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_we, cfg_addr, cfg_wdata,
    output cfg_rdata, cfg_ready
  );
endinterface

// File: rtl/io_mux_in_sync.sv
// One pad input: 2-FF synchroniser, followed by a FILT_LEN-sample glitch filter
// when IO_MUX_FILTER_EN is defined.
module io_mux_in_sync #(
  parameter int   FILT_LEN = 3,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pad_in,
  output logic fn_in
);

  if (FILT_LEN < 1) begin : g_bad_filt_len
    $error("io_mux_in_sync: FILT_LEN must be at least 1");
  end

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = pad_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= RST_VAL;
      sync2_q <= RST_VAL;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef IO_MUX_FILTER_EN
  localparam int CNT_W = $clog2(FILT_LEN + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             filt_q, filt_d;

  // Counts consecutive disagreeing samples; the FILT_LEN-th one flips the output.
  always_comb begin
    cnt_d  = '0;
    filt_d = filt_q;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_W'(FILT_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      filt_q <= RST_VAL;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign fn_in = filt_q;
`else
  assign fn_in = sync2_q;
`endif

endmodule

// File: rtl/io_pin_mux.sv
// Run-time pad multiplexer: register file + IDLE/ACK access FSM, registered output
// muxes with open-drain emulation, per-pin input synchronisers (filter: IO_MUX_FILTER_EN).
module io_pin_mux
  import io_mux_pkg::*;
#(
  parameter int                  NUM_PINS  = 8,
  parameter int                  NUM_FUNCS = 4,
  parameter int                  FILT_LEN  = 3,
  parameter logic [NUM_PINS-1:0] IN_RST    = '0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  io_pin_mux_if.slave                     cfg,
  input  logic [NUM_FUNCS*NUM_PINS-1:0]   fn_out,
  input  logic [NUM_FUNCS*NUM_PINS-1:0]   fn_oe,
  output logic [NUM_PINS-1:0]             fn_in,
  input  logic [NUM_PINS-1:0]             pad_in,
  output logic [NUM_PINS-1:0]             pad_out,
  output logic [NUM_PINS-1:0]             pad_oe,
  output cfg_state_e                      dbg_state
);

  localparam int FSEL_W   = fsel_w(NUM_FUNCS);
  localparam int FSEL_TOT = NUM_PINS * FSEL_W;
  localparam int IDX_W    = $clog2(NUM_FUNCS * NUM_PINS);

  if (NUM_PINS < 1 || NUM_PINS > 16 || NUM_FUNCS < 2 || NUM_FUNCS > 4 ||
      (NUM_FUNCS & (NUM_FUNCS - 1)) != 0) begin : g_bad_params
    $error("io_pin_mux: NUM_PINS must be 1..16, NUM_FUNCS a power of 2 in 2..4");
  end

  cfg_state_e            state_q, state_d;
  logic [FSEL_TOT-1:0]   fsel_q, fsel_d;
  logic [NUM_PINS-1:0]   od_q, od_d;
  logic                  lock_q, lock_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [NUM_PINS-1:0]   pad_out_q, pad_out_d;
  logic [NUM_PINS-1:0]   pad_oe_q, pad_oe_d;
  logic                  unused_wdata;

  assign unused_wdata = ^cfg.cfg_wdata;

  function automatic logic [IDX_W-1:0] fn_idx(input logic [FSEL_W-1:0] sel, input int pin);
    return IDX_W'(int'(sel) * NUM_PINS + pin);
  endfunction

  // Access FSM: a request is decoded and committed on the edge that enters ACK.
  always_comb begin
    state_d = state_q;
    fsel_d  = fsel_q;
    od_d    = od_q;
    lock_d  = lock_q;
    rdata_d = '0;
    case (state_q)
      CFG_IDLE: begin
        if (cfg.cfg_valid) begin
          state_d = CFG_ACK;
          if (cfg.cfg_we) begin
            case (cfg.cfg_addr)
              IO_MUX_FSEL: if (!lock_q) fsel_d = cfg.cfg_wdata[FSEL_TOT-1:0];
              IO_MUX_OD:   if (!lock_q) od_d   = cfg.cfg_wdata[NUM_PINS-1:0];
              IO_MUX_LOCK: lock_d = lock_q | cfg.cfg_wdata[0];
              default: ;
            endcase
          end else begin
            case (cfg.cfg_addr)
              IO_MUX_FSEL: rdata_d = 32'(fsel_q);
              IO_MUX_OD:   rdata_d = 32'(od_q);
              IO_MUX_LOCK: rdata_d = {31'b0, lock_q};
              IO_MUX_IN:   rdata_d = 32'(fn_in);
              default:     rdata_d = '0;
            endcase
          end
        end
      end
      CFG_ACK:  state_d = CFG_IDLE;
      default:  state_d = CFG_IDLE;
    endcase
  end

  // Open-drain pins never drive high: they only enable the pad to pull low.
  always_comb begin
    pad_out_d = '0;
    pad_oe_d  = '0;
    for (int p = 0; p < NUM_PINS; p++) begin
      if (od_q[p]) begin
        pad_out_d[p] = 1'b0;
        pad_oe_d[p]  = ~fn_out[fn_idx(fsel_q[p*FSEL_W +: FSEL_W], p)] &
                        fn_oe[fn_idx(fsel_q[p*FSEL_W +: FSEL_W], p)];
      end else begin
        pad_out_d[p] = fn_out[fn_idx(fsel_q[p*FSEL_W +: FSEL_W], p)];
        pad_oe_d[p]  = fn_oe[fn_idx(fsel_q[p*FSEL_W +: FSEL_W], p)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CFG_IDLE;
      fsel_q    <= '0;
      od_q      <= '0;
      lock_q    <= 1'b0;
      rdata_q   <= '0;
      pad_out_q <= '0;
      pad_oe_q  <= '0;
    end else begin
      state_q   <= state_d;
      fsel_q    <= fsel_d;
      od_q      <= od_d;
      lock_q    <= lock_d;
      rdata_q   <= rdata_d;
      pad_out_q <= pad_out_d;
      pad_oe_q  <= pad_oe_d;
    end
  end

  assign cfg.cfg_ready = (state_q == CFG_ACK);
  assign cfg.cfg_rdata = rdata_q;
  assign pad_out       = pad_out_q;
  assign pad_oe        = pad_oe_q;
  assign dbg_state     = state_q;

  for (genvar p = 0; p < NUM_PINS; p++) begin : g_in
    io_mux_in_sync #(
      .FILT_LEN (FILT_LEN),
      .RST_VAL  (IN_RST[p])
    ) u_in_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .pad_in (pad_in[p]),
      .fn_in  (fn_in[p])
    );
  end

endmodule

// File: tb/tb_io_pin_mux.sv
// Directed + randomized bench for io_pin_mux against a behavioural pad/register model.
module tb_io_pin_mux;
  import io_mux_pkg::*;

  localparam int NP = 8;
  localparam int NF = 4;
  localparam int FL = 3;
`ifdef IO_MUX_FILTER_EN
  localparam int IN_LAT = 2 + FL;
`else
  localparam int IN_LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [NF*NP-1:0] fn_out = '0;
  logic [NF*NP-1:0] fn_oe = '0;
  logic [NP-1:0]    fn_in;
  logic [NP-1:0]    pad_in = '0;
  logic [NP-1:0]    pad_out;
  logic [NP-1:0]    pad_oe;
  cfg_state_e       dbg_state;

  io_pin_mux_if cfg_if ();

  io_pin_mux #(
    .NUM_PINS (NP), .NUM_FUNCS (NF), .FILT_LEN (FL), .IN_RST ('0)
  ) dut (
    .clk (clk), .rst_n (rst_n), .cfg (cfg_if),
    .fn_out (fn_out), .fn_oe (fn_oe), .fn_in (fn_in),
    .pad_in (pad_in), .pad_out (pad_out), .pad_oe (pad_oe),
    .dbg_state (dbg_state)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model state
  int          fsel_m[NP];
  logic [NP-1:0] od_m;
  logic        lock_m;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fsel_word();
    logic [31:0] w = '0;
    for (int p = 0; p < NP; p++) w = w | (32'(fsel_m[p]) << (2 * p));
    return w;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) fsel_m[p] = 0;
    od_m = '0;
    lock_m = 1'b0;
  endtask

  task automatic model_write(input logic [3:0] addr, input logic [31:0] d);
    if (addr == 4'h0 && !lock_m) for (int p = 0; p < NP; p++) fsel_m[p] = int'((d >> (2 * p)) & 32'h3);
    else if (addr == 4'h4 && !lock_m) od_m = d[NP-1:0];
    else if (addr == 4'h8 && d[0]) lock_m = 1'b1;
  endtask

  // Each pad follows the selected function; an open-drain pad only ever pulls low.
  task automatic exp_pads(input logic [NF*NP-1:0] fo, input logic [NF*NP-1:0] foe,
                          output logic [NP-1:0] eo, output logic [NP-1:0] eoe);
    for (int p = 0; p < NP; p++) begin
      logic o, e;
      o = fo[fsel_m[p] * NP + p];
      e = foe[fsel_m[p] * NP + p];
      eo[p]  = od_m[p] ? 1'b0 : o;
      eoe[p] = od_m[p] ? (~o & e) : e;
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  task automatic bus(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd);
    int pulses = 0;
    bit got = 0;
    rd = '0;
    @(posedge clk); #1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_we    = we;
    cfg_if.cfg_addr  = addr;
    cfg_if.cfg_wdata = wd;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (cfg_if.cfg_ready) begin
        got = 1;
        rd = cfg_if.cfg_rdata;
        pulses++;
      end
    end
    @(posedge clk); #1;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_we    = 1'b0;
    @(negedge clk);
    if (cfg_if.cfg_ready) pulses++;
    check("ready_pulse_count", 32'(pulses), 32'd1);
    if (we) model_write(addr, wd);
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] d);
    logic [31:0] rd;
    bus(1'b1, addr, d, rd);
  endtask

  task automatic rd_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    bus(1'b0, addr, 32'h0, rd);
    check(tag, rd, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Random traffic on fn_out/fn_oe/pad_in; pads checked one cycle late, fn_in by history.
  task automatic run_random(input int n);
    logic [NF*NP-1:0] prev_out, prev_oe;
    logic [NP-1:0]    hist[$];
    logic [NP-1:0]    filt, eo, eoe, exp_in;
    prev_out = fn_out;
    prev_oe  = fn_oe;
    filt     = pad_in;
    hist     = {};
    repeat (FL + 3) hist.push_back(pad_in);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      fn_out = {$urandom, $urandom};
      fn_oe  = {$urandom, $urandom};
      pad_in = pad_in ^ (NP'($urandom) & NP'($urandom) & NP'($urandom));
      hist.push_back(pad_in);
      @(negedge clk);
      exp_pads(prev_out, prev_oe, eo, eoe);
      check("rand_pad_out", 32'(pad_out), 32'(eo));
      check("rand_pad_oe", 32'(pad_oe), 32'(eoe));
`ifdef IO_MUX_FILTER_EN
      for (int b = 0; b < NP; b++) begin
        bit all_diff = 1;
        for (int j = 0; j < FL; j++) if (hist[$-3-j][b] == filt[b]) all_diff = 0;
        if (all_diff) filt[b] = ~filt[b];
      end
      exp_in = filt;
`else
      exp_in = hist[$-2];
`endif
      check("rand_fn_in", 32'(fn_in), 32'(exp_in));
      prev_out = fn_out;
      prev_oe  = fn_oe;
      if (hist.size() > 16) void'(hist.pop_front());
    end
  endtask

  task automatic measure_in(input int bit_idx, input int fall_at, output int lat);
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == fall_at) pad_in[bit_idx] = 1'b0;
      @(negedge clk);
      if (fn_in[bit_idx] && lat == 0) lat = c;
    end
  endtask

  initial begin
    int lat;
    logic [31:0] d;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_we    = 1'b0;
    cfg_if.cfg_addr  = '0;
    cfg_if.cfg_wdata = '0;

    // 1: reset
    do_reset();
    @(negedge clk);
    check("rst_pad_oe", 32'(pad_oe), 32'h0);
    check("rst_pad_out", 32'(pad_out), 32'h0);
    check("rst_ready", 32'(cfg_if.cfg_ready), 32'h0);
    check("rst_rdata", cfg_if.cfg_rdata, 32'h0);
    check("rst_fn_in", 32'(fn_in), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(CFG_IDLE));
    rd_check("rst_fsel", 4'h0, 32'h0);
    rd_check("rst_od", 4'h4, 32'h0);
    rd_check("rst_lock", 4'h8, 32'h0);

    // 2: pin1 on function 1, one cycle of output latency
    wr(4'h0, 32'h0000_0004);
    rd_check("fsel_pin1", 4'h0, 32'h4);
    @(posedge clk); #1;
    fn_out = '0; fn_oe = '0;
    fn_out[1*NP+1] = 1'b1; fn_oe[1*NP+1] = 1'b1;
    @(negedge clk);
    check("pin1_latency_out", 32'(pad_out[1]), 32'h0);
    @(negedge clk);
    check("pin1_out", 32'(pad_out[1]), 32'h1);
    check("pin1_oe", 32'(pad_oe[1]), 32'h1);
    @(posedge clk); #1;
    fn_out[1*NP+1] = 1'b0; fn_out[0*NP+1] = 1'b1;
    idle(1); @(negedge clk);
    check("pin1_ignores_fn0", 32'(pad_out[1]), 32'h0);

    // 3: open-drain pin4 on function 2
    wr(4'h4, 32'h10);
    wr(4'h0, 32'h0000_0204);
    @(posedge clk); #1;
    fn_out[2*NP+4] = 1'b0; fn_oe[2*NP+4] = 1'b1;
    idle(1); @(negedge clk);
    check("od_low_oe", 32'(pad_oe[4]), 32'h1);
    check("od_low_out", 32'(pad_out[4]), 32'h0);
    @(posedge clk); #1;
    fn_out[2*NP+4] = 1'b1;
    idle(1); @(negedge clk);
    check("od_high_oe", 32'(pad_oe[4]), 32'h0);
    check("od_high_out", 32'(pad_out[4]), 32'h0);

    // random configurations, unmapped offsets and IN readback
    for (int r = 0; r < 6; r++) begin
      idle(8);
      wr(4'h0, $urandom);
      wr(4'h4, $urandom);
      d = $urandom;
      wr(4'(2 + 4 * $urandom_range(0, 3)), d);
      rd_check("unmapped_read", 4'(1 + 4 * $urandom_range(0, 3)), 32'h0);
      wr(4'hC, $urandom);
      rd_check("rand_fsel", 4'h0, fsel_word());
      rd_check("rand_od", 4'h4, 32'(od_m));
      rd_check("rand_in_reg", 4'hC, 32'(pad_in));
      run_random(25);
    end

    // 4: lock freezes FSEL/OD until reset
    wr(4'h8, 32'h1);
    rd_check("lock_set", 4'h8, 32'h1);
    wr(4'h0, 32'h0000_FFFF);
    wr(4'h4, 32'hFF);
    wr(4'h8, 32'h0);
    rd_check("lock_fsel_kept", 4'h0, fsel_word());
    rd_check("lock_od_kept", 4'h4, 32'(od_m));
    rd_check("lock_sticky", 4'h8, 32'h1);
    run_random(20);

    // 5: reset clears lock; pad_in[0] step reaches fn_in after the input latency
    pad_in = '0;
    do_reset();
    idle(8);
    rd_check("lock_cleared", 4'h8, 32'h0);
    rd_check("fsel_cleared", 4'h0, 32'h0);
    pad_in[0] = 1'b1;
    measure_in(0, 99, lat);
    check("in_step_latency", 32'(lat), 32'(IN_LAT));
    rd_check("in_reg_bit0", 4'hC, 32'h1);

`ifdef IO_MUX_FILTER_EN
    // 6: short pulse rejected, long pulse passes after 2+FILT_LEN cycles
    @(posedge clk); #1;
    pad_in[2] = 1'b1;
    measure_in(2, 2, lat);
    check("filt_short_pulse", 32'(lat), 32'h0);
    @(posedge clk); #1;
    pad_in[2] = 1'b1;
    measure_in(2, 4, lat);
    check("filt_long_pulse", 32'(lat), 32'(2 + FL));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
